uart_rx_controller: RTL

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_controller.sv
// UART receive controller: oversampled start/data/stop framing that drives an external SIPO.
// Latency: rx_done/frame_err pulse one clk after the stop-bit centre tick (2-flop sync + registered outputs).
// Backpressure: none; the serial line cannot be stalled, and each frame result is a single-clk pulse.
//
// Ports:
//   clk, reset_n       sole clock, synchronous active-low reset
//   s_tick             oversample strobe, OS pulses per bit period
//   rx                 asynchronous serial input, idle high
//   sipo_start         one-clk pulse that clears/arms the external shift register
//   sipo_s_in          synchronized rx, serial input of the shift register
//   sipo_shift         one-clk pulse at each data-bit centre
//   sipo_data          shift register parallel contents (LSB-first frame)
//   dout               last good received word
//   rx_done            one-clk pulse when dout updates
//   frame_err          one-clk pulse on a low stop bit
//   busy               high in any state other than IDLE
//   state_reg          IDLE=0, START=1, DATA=2, STOP=3, BREAK=4
module uart_rx_controller #(
  parameter int N  = 8,
  parameter int OS = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_tick,
  input  logic         rx,
  output logic         sipo_start,
  output logic         sipo_s_in,
  output logic         sipo_shift,
  input  logic [N-1:0] sipo_data,
  output logic [N-1:0] dout,
  output logic         rx_done,
  output logic         frame_err,
  output logic         busy,
  output logic [2:0]   state_reg
);

  localparam int TW = $clog2(OS + 1);
  localparam int BW = $clog2(N + 1);

  // Counter values on which the decision tick is reached (the counter holds
  // the number of ticks already seen in the current interval).
  localparam logic [TW-1:0] HALF_LAST = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic            rx_meta_q;
  logic            rxs_q;
  logic            sipo_start_q;
  logic            sipo_shift_q;
  logic            rx_done_q;
  logic            frame_err_q;
  logic [N-1:0]    dout_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      sipo_start_q <= 1'b0;
      sipo_shift_q <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      dout_q       <= '0;
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      // All status outputs are single-cycle pulses unless re-asserted below.
      sipo_start_q <= 1'b0;
      sipo_shift_q <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q      <= S_START;
            tick_q       <= '0;
            bit_q        <= '0;
            sipo_start_q <= 1'b1;
          end
        end

        S_START: begin
          if (s_tick) begin
            if (tick_q == HALF_LAST) begin
              tick_q <= '0;
              // Still low at the start-bit centre: a real frame. Otherwise a
              // glitch, dropped silently.
              state_q <= rxs_q ? S_IDLE : S_DATA;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (s_tick) begin
            if (tick_q == FULL_LAST) begin
              tick_q       <= '0;
              sipo_shift_q <= 1'b1;
              if (bit_q == BIT_LAST) begin
                bit_q   <= '0;
                state_q <= S_STOP;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (s_tick) begin
            if (tick_q == FULL_LAST) begin
              tick_q <= '0;
              if (rxs_q) begin
                // The last shift happened a full bit period ago, so
                // sipo_data is settled here.
                dout_q    <= sipo_data;
                rx_done_q <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        S_BREAK: begin
          // A held-low line must not be mistaken for a new start bit.
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign sipo_start = sipo_start_q;
  assign sipo_shift = sipo_shift_q;
  assign sipo_s_in  = rxs_q;
  assign dout       = dout_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
  assign state_reg  = state_q;

endmodule
